// File: rtl/unit_phase_sequencer.sv
// Layer phase sequencer: runs a forward (and optionally backward) propagation pass.
// It drives registered enables and a gated oscillator to every unit in the layer.
module unit_phase_sequencer #(
    parameter int unsigned FD_CYCLES = 4,
    parameter int unsigned BK_CYCLES = 4,
    parameter int unsigned OSC_DIV   = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        train_in,
    input  logic        abort_in,
    output logic        oscillator,
    output logic        fd_prop,
    output logic        bk_prop,
    output logic        busy_out,
    output logic        done_out,
    output logic [2:0]  phase_out,
    output logic [15:0] pass_count_out
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FWD    = 3'd1,
        S_SETTLE = 3'd2,
        S_BWD    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [7:0] FD_LAST  = 8'(FD_CYCLES - 1);
    localparam logic [7:0] BK_LAST  = 8'(BK_CYCLES - 1);
    localparam logic [7:0] DIV_LAST = 8'(OSC_DIV - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  div_q, div_d;
    logic        train_q, train_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;
    logic        osc_q, osc_d;
    logic        fd_q, fd_d;
    logic        bk_q, bk_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [2:0]  phase_q, phase_d;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            train_q    <= 1'b0;
            pass_cnt_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            train_q    <= train_d;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        train_d    = train_q;
        pass_cnt_d = pass_cnt_q;
        if (state_q != S_IDLE && abort_in) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // abort_in outranks start_in even while idle
                    if (start_in && !abort_in) begin
                        state_d = S_FWD;
                        train_d = train_in;
                    end
                end
                S_FWD:    if (cnt_q == FD_LAST) state_d = train_q ? S_SETTLE : S_DONE;
                S_SETTLE: state_d = S_BWD;
                S_BWD:    if (cnt_q == BK_LAST) state_d = S_DONE;
                S_DONE: begin
                    state_d    = S_IDLE;
                    pass_cnt_d = pass_cnt_q + 16'd1;
                end
                default:  state_d = S_IDLE;
            endcase
        end
        cnt_d = (state_d != state_q || state_q == S_IDLE) ? 8'd0 : cnt_q + 8'd1;
    end

    // Outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        osc_d   = 1'b0;
        div_d   = 8'd0;
        fd_d    = (state_d == S_FWD);
        bk_d    = (state_d == S_BWD);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        phase_d = state_d;
        if ((state_d == S_FWD || state_d == S_BWD) && state_d == state_q) begin
            if (div_q == DIV_LAST) begin
                div_d = 8'd0;
                osc_d = ~osc_q;
            end else begin
                div_d = div_q + 8'd1;
                osc_d = osc_q;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            osc_q   <= 1'b0;
            div_q   <= 8'd0;
            fd_q    <= 1'b0;
            bk_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            phase_q <= 3'd0;
        end else begin
            osc_q   <= osc_d;
            div_q   <= div_d;
            fd_q    <= fd_d;
            bk_q    <= bk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            phase_q <= phase_d;
        end
    end

    assign oscillator     = osc_q;
    assign fd_prop        = fd_q;
    assign bk_prop        = bk_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign phase_out      = phase_q;
    assign pass_count_out = pass_cnt_q;

endmodule

// File: tb/tb_unit_phase_sequencer.sv
// Directed table-driven bench for unit_phase_sequencer, plus hand sequences for
// back-to-back passes with FD_CYCLES=1 and pass-counter wrap.
module tb_unit_phase_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, start, train, abort;
    logic        osc, fd, bk, busy, done;
    logic [2:0]  phase;
    logic [15:0] cnt;

    logic        start1, train1, abort1;
    logic        osc1, fd1, bk1, busy1, done1;
    logic [2:0]  phase1;
    logic [15:0] cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    unit_phase_sequencer dut (
        .clk_in(clk), .rst_in(rst_n), .start_in(start), .train_in(train), .abort_in(abort),
        .oscillator(osc), .fd_prop(fd), .bk_prop(bk), .busy_out(busy), .done_out(done),
        .phase_out(phase), .pass_count_out(cnt)
    );

    unit_phase_sequencer #(.FD_CYCLES(1), .BK_CYCLES(1), .OSC_DIV(1)) dut1 (
        .clk_in(clk), .rst_in(rst_n), .start_in(start1), .train_in(train1), .abort_in(abort1),
        .oscillator(osc1), .fd_prop(fd1), .bk_prop(bk1), .busy_out(busy1), .done_out(done1),
        .phase_out(phase1), .pass_count_out(cnt1)
    );

    typedef struct {
        logic        st, tr, ab, rn;
        logic        osc, fd, bk, busy, done;
        logic [2:0]  ph;
        logic [15:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, tr, ab, rn, input logic o, f, b, bu, d,
                       input logic [2:0] ph, input logic [15:0] c);
        vec_t v;
        v.st = st; v.tr = tr; v.ab = ab; v.rn = rn;
        v.osc = o; v.fd = f; v.bk = b; v.busy = bu; v.done = d; v.ph = ph; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; train = 1'b0; abort = 1'b0;
        start1 = 1'b0; train1 = 1'b0; abort1 = 1'b0;

        // training pass, start/train toggled mid-pass
        add(1,1,0,1, 0,1,0,1,0,1,0);
        add(0,0,0,1, 0,1,0,1,0,1,0);
        add(1,0,0,1, 1,1,0,1,0,1,0);
        add(0,0,0,1, 1,1,0,1,0,1,0);
        add(0,0,0,1, 0,0,0,1,0,2,0);
        add(0,0,0,1, 0,0,1,1,0,3,0);
        add(0,0,0,1, 0,0,1,1,0,3,0);
        add(0,0,0,1, 1,0,1,1,0,3,0);
        add(0,0,0,1, 1,0,1,1,0,3,0);
        add(0,0,0,1, 0,0,0,1,1,4,0);
        add(0,0,0,1, 0,0,0,0,0,0,1);
        // inference pass
        add(1,0,0,1, 0,1,0,1,0,1,1);
        add(0,1,0,1, 0,1,0,1,0,1,1);
        add(0,0,0,1, 1,1,0,1,0,1,1);
        add(0,0,0,1, 1,1,0,1,0,1,1);
        add(0,0,0,1, 0,0,0,1,1,4,1);
        add(0,0,0,1, 0,0,0,0,0,0,2);
        // training pass aborted in its second BWD cycle
        add(1,1,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 0,0,0,1,0,2,2);
        add(0,0,0,1, 0,0,1,1,0,3,2);
        add(0,0,0,1, 0,0,1,1,0,3,2);
        add(0,0,1,1, 0,0,0,0,0,0,2);
        // abort and start together in IDLE
        add(1,1,1,1, 0,0,0,0,0,0,2);
        add(0,0,0,1, 0,0,0,0,0,0,2);
        // abort in FWD
        add(1,0,0,1, 0,1,0,1,0,1,2);
        add(0,0,1,1, 0,0,0,0,0,0,2);
        // abort in DONE
        add(1,0,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 0,0,0,1,1,4,2);
        add(0,0,1,1, 0,0,0,0,0,0,2);
        // reset during BWD, then a clean pass
        add(1,1,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 0,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 1,1,0,1,0,1,2);
        add(0,0,0,1, 0,0,0,1,0,2,2);
        add(0,0,0,1, 0,0,1,1,0,3,2);
        add(0,0,0,0, 0,0,0,0,0,0,0);
        add(1,1,0,0, 0,0,0,0,0,0,0);
        add(1,0,0,1, 0,1,0,1,0,1,0);
        add(0,0,0,1, 0,1,0,1,0,1,0);
        add(0,0,0,1, 1,1,0,1,0,1,0);
        add(0,0,0,1, 1,1,0,1,0,1,0);
        add(0,0,0,1, 0,0,0,1,1,4,0);
        add(0,0,0,1, 0,0,0,0,0,0,1);

        repeat (3) @(negedge clk);
        chk("reset_state", {8'd0, osc, fd, bk, busy, done, phase, cnt}, 32'd0);
        chk("reset_state_dut1", {8'd0, osc1, fd1, bk1, busy1, done1, phase1, cnt1}, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            start = tbl[i].st; train = tbl[i].tr; abort = tbl[i].ab; rst_n = tbl[i].rn;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d", i),
                {8'd0, osc, fd, bk, busy, done, phase, cnt},
                {8'd0, tbl[i].osc, tbl[i].fd, tbl[i].bk, tbl[i].busy, tbl[i].done,
                 tbl[i].ph, tbl[i].cnt});
        end
        @(negedge clk);
        start = 1'b0; train = 1'b0; abort = 1'b0; rst_n = 1'b1;

        // back-to-back inference passes with FD_CYCLES=1: FWD, DONE, IDLE repeating
        start1 = 1'b1; train1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            logic [2:0] exp_ph;
            @(posedge clk);
            #1;
            exp_ph = (k % 3 == 1) ? 3'd1 : ((k % 3 == 2) ? 3'd4 : 3'd0);
            chk($sformatf("b2b_phase_e%0d", k), {29'd0, phase1}, {29'd0, exp_ph});
            chk($sformatf("b2b_count_e%0d", k), {16'd0, cnt1}, 32'(k / 3));
        end
        @(negedge clk);
        start1 = 1'b0;

        // pass counter wrap from 0xFFFF
        @(negedge clk);
        force dut.pass_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        chk("wrap_preload", {16'd0, cnt}, 32'h0000FFFF);
        @(negedge clk);
        release dut.pass_cnt_q;
        start = 1'b1; train = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) start = 1'b0;
            if (k == 5) chk("wrap_done", {15'd0, done, cnt}, 32'h0001FFFF);
            if (k == 6) chk("wrap_zero", {15'd0, done, cnt}, 32'h00000000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/unit_phase_sequencer.md
UNIT_PHASE_SEQUENCER -- requirements
Module: unit_phase_sequencer

Interface
REQ-001 Parameter FD_CYCLES, default 4: number of cycles fd_prop is held high per pass; legal range 1..255.
REQ-002 Parameter BK_CYCLES, default 4: number of cycles bk_prop is held high per pass; legal range 1..255.
REQ-003 Parameter OSC_DIV, default 2: oscillator half-period in cycles; legal range 1..255.
REQ-004 clk_in  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-low.
REQ-006 start_in  input  1  request one pass; sampled only in IDLE.
REQ-007 train_in  input  1  sampled together with start_in; 1 = forward then backward, 0 = forward only.
REQ-008 abort_in  input  1  terminate the current pass.
REQ-009 oscillator  output  1  oscillator drive to every unit in the layer.
REQ-010 fd_prop  output  1  forward-propagate enable to the units.
REQ-011 bk_prop  output  1  backward-propagate enable to the units.
REQ-012 busy_out  output  1  high in every state except IDLE.
REQ-013 done_out  output  1  one-cycle pulse at pass completion.
REQ-014 phase_out  output  3  current state encoding: IDLE=0, FWD=1, SETTLE=2, BWD=3, DONE=4.
REQ-015 pass_count_out  output  16  count of completed passes.

Function
REQ-016 The block SHALL implement the FSM states IDLE, FWD, SETTLE, BWD and DONE, with all outputs registered.
REQ-017 IDLE: if start_in=1 at an edge, the block SHALL latch train_in and enter FWD on that edge; otherwise it SHALL stay in IDLE.
REQ-018 FWD: fd_prop SHALL be 1 for exactly FD_CYCLES consecutive cycles. The next state SHALL be SETTLE if the latched train=1, else DONE.
REQ-019 SETTLE: the state SHALL last exactly 1 cycle, with fd_prop=bk_prop=0 and oscillator=0, then go to BWD.
REQ-020 BWD: bk_prop SHALL be 1 for exactly BK_CYCLES consecutive cycles, then go to DONE.
REQ-021 DONE: the state SHALL last exactly 1 cycle with done_out=1, and pass_count_out SHALL increment by 1 (wraps 0xFFFF->0x0000) on leaving DONE; the next state SHALL be IDLE.
REQ-022 fd_prop and bk_prop SHALL never both be 1.
REQ-023 The oscillator SHALL be 0 on the first cycle of FWD and of BWD, toggle every OSC_DIV cycles within that phase, and be 0 in IDLE, SETTLE and DONE.
REQ-024 The phase cycle counter SHALL be cleared on every phase entry and be wide enough for 255 without overflow.
REQ-025 start_in and train_in SHALL be ignored in FWD, SETTLE, BWD and DONE; the latched train value SHALL be stable for the whole pass.
REQ-026 abort_in=1 in any non-IDLE state SHALL force IDLE on the next edge, with all enables/oscillator 0, no done_out pulse and no pass_count increment.
REQ-027 Priority SHALL be reset > abort_in > start_in; abort_in and start_in both high in IDLE SHALL leave the block in IDLE.
REQ-028 A new pass SHALL be accepted no earlier than the first IDLE cycle after DONE. Minimum pass-to-pass spacing SHALL be FD_CYCLES+2 cycles (inference) and FD_CYCLES+BK_CYCLES+3 cycles (training).

Reset
REQ-029 While rst_in=0 at an edge, the block SHALL enter IDLE and drive oscillator=0, fd_prop=0, bk_prop=0, busy_out=0, done_out=0, phase_out=0 and pass_count_out=0.
REQ-030 Reset asserted mid-pass SHALL abandon the pass with no done_out pulse; the first edge with rst_in=1 SHALL leave the block in IDLE.

Verification
REQ-031 Default params, start_in=1 with train_in=0 at cycle 0 -> fd_prop high cycles 1-4, oscillator 0,0,1,1, DONE at cycle 5, done_out at cycle 5, pass_count_out=1 from cycle 6.
REQ-032 Default params, train_in=1 -> FWD cycles 1-4, SETTLE cycle 5, bk_prop high cycles 6-9, done_out at cycle 10, busy_out high cycles 1-10.
REQ-033 abort_in=1 at cycle 7 of a training pass -> IDLE at cycle 8, bk_prop=0, no done_out, pass_count_out unchanged.
REQ-034 start_in held high continuously with train_in=0 and FD_CYCLES=1 -> passes start every 3 cycles, and pass_count_out counts 1,2,3 on the expected cycles.
REQ-035 pass_count_out preloaded via 65535 completed passes (or forced) -> next pass wraps it to 0.
REQ-036 rst_in=0 during BWD -> all outputs at reset values on the next cycle, and a start_in after reset release begins a clean FWD.
